// File: rtl/cpu_defs.sv
// Shared CPU definitions: memory map, exception codes and the fetch entry record.
package cpu_defs;
  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  localparam logic [31:0] IM_BASE  = 32'h0000_3000;
  localparam int          IM_WORDS = 4096;
  localparam int          IM_AW    = $clog2(IM_WORDS);
  localparam logic [31:0] IM_END   = IM_BASE + 32'(4 * IM_WORDS);
  localparam logic [4:0]  EXC_NONE = 5'd0;
  localparam logic [4:0]  EXC_ADEL = 5'd4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [4:0]  exc;
  } fetch_entry_t;

  // Misaligned or outside the instruction memory window.
  function automatic logic fetch_addr_err(input logic [31:0] pc);
    return (pc[1:0] != 2'b00) || (pc < IM_BASE) || (pc >= IM_END);
  endfunction
endpackage

// File: rtl/ifetch_buffer_if.sv
// Fetch-stage bundle: PC register side, instruction BRAM side and decode side.
interface ifetch_buffer_if;
  import cpu_defs::*;

  logic [31:0]      PCF;
  logic             PCEn;
  logic [IM_AW-1:0] ImAddr;
  logic [31:0]      ImRdata;
  logic             StallD;
  logic             FlushD;
  logic             ValidD;
  logic [31:0]      InstrD;
  logic [31:0]      PCOutD;
  logic [4:0]       ExcD;

  modport master (
    input  PCF, ImRdata, StallD, FlushD,
    output PCEn, ImAddr, ValidD, InstrD, PCOutD, ExcD
  );

  modport slave (
    output PCF, ImRdata, StallD, FlushD,
    input  PCEn, ImAddr, ValidD, InstrD, PCOutD, ExcD
  );
endinterface

// File: rtl/fetch_fifo2.sv
// Small FIFO of fetch entries with synchronous flush; head reads as zero when empty.
module fetch_fifo2
  import cpu_defs::*;
#(
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  fetch_entry_t  din,
  output fetch_entry_t  head,
  output logic [CW-1:0] count
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  typedef logic [PW-1:0] ptr_t;

  fetch_entry_t   mem_reg [DEPTH];
  ptr_t           rd_ptr_reg, rd_ptr_next;
  ptr_t           wr_ptr_reg, wr_ptr_next;
  logic [CW-1:0]  count_reg, count_next;
  logic [DEPTH-1:0] wr_en;
  logic           do_push, do_pop;

  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == ptr_t'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign do_push = push & ~flush;
  assign do_pop  = pop & (count_reg != '0) & ~flush;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_wr
      assign wr_en[gi] = do_push & (wr_ptr_reg == ptr_t'(gi));
    end
  endgenerate

  always_comb begin
    rd_ptr_next = rd_ptr_reg;
    wr_ptr_next = wr_ptr_reg;
    count_next  = count_reg;
    if (flush) begin
      rd_ptr_next = '0;
      wr_ptr_next = '0;
      count_next  = '0;
    end else begin
      if (do_push) wr_ptr_next = ptr_inc(wr_ptr_reg);
      if (do_pop)  rd_ptr_next = ptr_inc(rd_ptr_reg);
      count_next = count_reg + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_reg[i] <= '0;
    end else begin
      rd_ptr_reg <= rd_ptr_next;
      wr_ptr_reg <= wr_ptr_next;
      count_reg  <= count_next;
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_en[i]) mem_reg[i] <= din;
      end
    end
  end

  assign head  = (count_reg != '0) ? mem_reg[rd_ptr_reg] : '0;
  assign count = count_reg;

  // The upstream credit logic must never push into a full buffer without a pop.
  assert property (@(posedge Clk) disable iff (Reset)
    !(do_push && !do_pop && count_reg == CW'(DEPTH)));
endmodule

// File: rtl/ifetch_buffer.sv
// Fetch stage: issues PCF to the instruction BRAM, tracks the in-flight request
// and queues returned words so decode stalls never lose a fetched word.
module ifetch_buffer
  import cpu_defs::*;
#(
  parameter int DEPTH = 2
) (
  input  logic            Clk,
  input  logic            Reset,
  ifetch_buffer_if.master bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int OW = CW + 1;

  logic          inflight_v_reg;
  logic [31:0]   inflight_pc_reg;
  logic [4:0]    inflight_exc_reg;
  fetch_entry_t  push_entry, head;
  logic [CW-1:0] count;
  logic [OW-1:0] occupancy;
  logic          valid, pop, issue, push, addr_err;

  assign addr_err   = fetch_addr_err(bus.PCF);
  assign bus.ImAddr = IM_AW'((bus.PCF - IM_BASE) >> 2);

  assign valid     = (count != '0);
  assign pop       = valid & ~bus.StallD;
  // Only issue when the returning word is guaranteed a free slot.
  assign occupancy = OW'(count) + OW'(inflight_v_reg);
  assign issue     = ~bus.FlushD & (occupancy < OW'(DEPTH) + OW'(pop));
  assign bus.PCEn  = issue | bus.FlushD;

  assign push             = inflight_v_reg & ~bus.FlushD;
  assign push_entry.pc    = inflight_pc_reg;
  assign push_entry.exc   = inflight_exc_reg;
  assign push_entry.instr = (inflight_exc_reg != EXC_NONE) ? 32'h0 : bus.ImRdata;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      inflight_v_reg   <= 1'b0;
      inflight_pc_reg  <= '0;
      inflight_exc_reg <= EXC_NONE;
    end else begin
      inflight_v_reg <= issue;
      if (issue) begin
        inflight_pc_reg  <= bus.PCF;
        inflight_exc_reg <= addr_err ? EXC_ADEL : EXC_NONE;
      end
    end
  end

  fetch_fifo2 #(.DEPTH(DEPTH), .CW(CW)) u_fifo (
    .Clk   (Clk),
    .Reset (Reset),
    .push  (push),
    .pop   (pop),
    .flush (bus.FlushD),
    .din   (push_entry),
    .head  (head),
    .count (count)
  );

  assign bus.ValidD = valid;
  assign bus.InstrD = head.instr;
  assign bus.PCOutD = head.pc;
  assign bus.ExcD   = head.exc;
endmodule

// File: tb/tb_ifetch_buffer.sv
// Bench for ifetch_buffer: PC register and BRAM environment plus a queue-based reference model.
module tb_ifetch_buffer;
  import cpu_defs::*;

  logic Clk = 1'b0;
  logic Reset = 1'b1;

  ifetch_buffer_if bus();

  ifetch_buffer #(.DEPTH(2)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus.master)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [4:0]  exc;
  } ent_t;

  ent_t q[$];
  bit   pend_v;
  ent_t pend;

  logic [31:0]      redirect;
  logic [IM_AW-1:0] addr_q;
  logic             pcen_q;
  logic             exp_valid, exp_pcen;
  logic [31:0]      exp_pc, exp_instr;
  logic [4:0]       exp_exc;

  function automatic logic [31:0] mem_word(input logic [31:0] idx);
    return 32'hC0DE_0000 ^ (idx * 32'h0001_9E37) ^ {idx[7:0], 24'h0};
  endfunction

  function automatic bit pc_bad(input logic [31:0] pc);
    return (pc % 4 != 0) || (pc < 32'h3000) || (pc >= 32'h7000);
  endfunction

  function automatic ent_t make_ent(input logic [31:0] pc);
    ent_t e;
    e.pc = pc;
    if (pc_bad(pc)) begin
      e.exc = 5'd4;
      e.instr = 32'h0;
    end else begin
      e.exc = 5'd0;
      e.instr = mem_word((pc - 32'h3000) / 4);
    end
    return e;
  endfunction

  function automatic logic [31:0] rand_target();
    int r;
    r = $urandom_range(0, 9);
    if (r == 0) return 32'h3000 + 32'(4 * $urandom_range(0, 4095)) + 32'($urandom_range(1, 3));
    if (r == 1) return ($urandom_range(0, 1) == 0) ? 32'h7000 + 32'(4 * $urandom_range(0, 63))
                                                  : 32'h2F00 + 32'(4 * $urandom_range(0, 63));
    return 32'h3000 + 32'(4 * $urandom_range(0, 4095));
  endfunction

  task automatic apply_reset();
    Reset = 1'b1;
    bus.PCF = RESET_PC;
    bus.StallD = 1'b0;
    bus.FlushD = 1'b0;
    bus.ImRdata = 32'h0;
    redirect = 32'h0;
    q.delete();
    pend_v = 1'b0;
    #1;
  endtask

  task automatic release_reset();
    Reset = 1'b0;
    #1;
  endtask

  // Drive this cycle's decode/redirect inputs and form the model's expected outputs.
  task automatic set_inputs(input logic stall, input logic flush, input logic [31:0] target);
    bit pop;
    int fill;
    bus.StallD = stall;
    bus.FlushD = flush;
    redirect = target;
    #1;
    pop = (q.size() > 0) && !stall;
    fill = q.size() + int'(pend_v) - int'(pop);
    exp_pcen = flush || (fill < 2);
    if (q.size() > 0) begin
      exp_valid = 1'b1;
      exp_pc = q[0].pc;
      exp_instr = q[0].instr;
      exp_exc = q[0].exc;
    end else begin
      exp_valid = 1'b0;
      exp_pc = 32'h0;
      exp_instr = 32'h0;
      exp_exc = 5'd0;
    end
  endtask

  // Advance the model and the environment (PC register, BRAM) across one clock edge.
  task automatic advance();
    logic [31:0] pcf;
    bit pop;
    int fill;
    pcen_q = bus.PCEn;
    addr_q = bus.ImAddr;
    pcf = bus.PCF;
    if (bus.FlushD) begin
      q.delete();
      pend_v = 1'b0;
    end else begin
      pop = (q.size() > 0) && !bus.StallD;
      fill = q.size() + int'(pend_v) - int'(pop);
      if (pop) q.delete(0);
      if (pend_v) q.push_back(pend);
      pend_v = (fill < 2);
      if (pend_v) pend = make_ent(pcf);
    end
    @(posedge Clk);
    #1;
    bus.ImRdata = mem_word(32'(addr_q));
    if (pcen_q) bus.PCF = bus.FlushD ? redirect : bus.PCF + 32'd4;
  endtask

  task automatic run_free(input int n);
    for (int i = 0; i < n; i++) begin
      set_inputs(1'b0, 1'b0, 32'h0);
      advance();
    end
  endtask

  task automatic test_reset();
    apply_reset();
    if (bus.ValidD !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", bus.ValidD); end
    checks++;
    if (bus.InstrD !== 32'h0 || bus.PCOutD !== 32'h0 || bus.ExcD !== 5'd0) begin
      failures++; $display("FAIL reset_head got instr=%h pc=%h exc=%0d exp=0", bus.InstrD, bus.PCOutD, bus.ExcD);
    end
    checks++;
    if (bus.PCEn !== 1'b1) begin failures++; $display("FAIL reset_pcen got=%b exp=1", bus.PCEn); end
    checks++;
    release_reset();
    // StallD while empty must not matter.
    for (int c = 0; c < 2; c++) begin
      set_inputs(1'b1, 1'b0, 32'h0);
      if (bus.ValidD !== 1'b0 || bus.PCEn !== 1'b1) begin
        failures++; $display("FAIL reset_fill c=%0d got valid=%b pcen=%b exp valid=0 pcen=1", c, bus.ValidD, bus.PCEn);
      end
      checks++;
      advance();
    end
    set_inputs(1'b0, 1'b0, 32'h0);
    if (bus.ValidD !== 1'b1 || bus.PCOutD !== 32'h3000 || bus.InstrD !== mem_word(0) || bus.ExcD !== 5'd0) begin
      failures++; $display("FAIL reset_first got valid=%b pc=%h instr=%h exc=%0d exp pc=00003000 instr=%h",
                           bus.ValidD, bus.PCOutD, bus.InstrD, bus.ExcD, mem_word(0));
    end
    checks++;
    advance();
    $display("test_reset done");
  endtask

  task automatic test_free_run();
    apply_reset();
    release_reset();
    for (int c = 0; c < 5; c++) begin
      set_inputs(1'b0, 1'b0, 32'h0);
      if (bus.PCEn !== 1'b1) begin failures++; $display("FAIL free_pcen c=%0d got=%b exp=1", c, bus.PCEn); end
      checks++;
      if (c >= 2) begin
        if (bus.ValidD !== 1'b1 || bus.PCOutD !== 32'h3000 + 32'(4 * (c - 2))) begin
          failures++; $display("FAIL free_head c=%0d got valid=%b pc=%h exp pc=%h", c, bus.ValidD, bus.PCOutD,
                               32'h3000 + 32'(4 * (c - 2)));
        end
        checks++;
      end
      advance();
    end
    $display("test_free_run done");
  endtask

  task automatic test_stall();
    apply_reset();
    release_reset();
    run_free(3);
    for (int c = 0; c < 3; c++) begin
      set_inputs(1'b1, 1'b0, 32'h0);
      if (bus.PCEn !== 1'b0 || bus.ValidD !== 1'b1 || bus.PCOutD !== 32'h3004) begin
        failures++; $display("FAIL stall_hold c=%0d got pcen=%b valid=%b pc=%h exp pcen=0 pc=00003004",
                             c, bus.PCEn, bus.ValidD, bus.PCOutD);
      end
      checks++;
      advance();
    end
    for (int c = 0; c < 4; c++) begin
      set_inputs(1'b0, 1'b0, 32'h0);
      if (bus.PCEn !== 1'b1 || bus.PCOutD !== 32'h3004 + 32'(4 * c) ||
          bus.InstrD !== mem_word(32'(1 + c))) begin
        failures++; $display("FAIL stall_release c=%0d got pcen=%b pc=%h instr=%h exp pc=%h",
                             c, bus.PCEn, bus.PCOutD, bus.InstrD, 32'h3004 + 32'(4 * c));
      end
      checks++;
      advance();
    end
    $display("test_stall done");
  endtask

  task automatic test_flush();
    for (int s = 0; s < 2; s++) begin
      apply_reset();
      release_reset();
      run_free(3);
      if (s == 0) begin
        set_inputs(1'b1, 1'b0, 32'h0);
        advance();
      end
      set_inputs(s == 0, 1'b1, 32'h4180);
      if (bus.PCEn !== 1'b1) begin failures++; $display("FAIL flush_pcen s=%0d got=%b exp=1", s, bus.PCEn); end
      checks++;
      advance();
      for (int c = 0; c < 2; c++) begin
        set_inputs(1'b0, 1'b0, 32'h0);
        if (bus.ValidD !== 1'b0 || bus.ExcD !== 5'd0) begin
          failures++; $display("FAIL flush_bubble s=%0d c=%0d got valid=%b exp=0", s, c, bus.ValidD);
        end
        checks++;
        advance();
      end
      set_inputs(1'b0, 1'b0, 32'h0);
      if (bus.ValidD !== 1'b1 || bus.PCOutD !== 32'h4180 || bus.InstrD !== mem_word(32'h460)) begin
        failures++; $display("FAIL flush_target s=%0d got valid=%b pc=%h instr=%h exp pc=00004180 instr=%h",
                             s, bus.ValidD, bus.PCOutD, bus.InstrD, mem_word(32'h460));
      end
      checks++;
      advance();
    end
    $display("test_flush done");
  endtask

  task automatic test_addr_err();
    logic [31:0] targets [4];
    logic [4:0]  excs [4];
    targets = '{32'h3002, 32'h7000, 32'h2FFC, 32'h6FFC};
    excs = '{5'd4, 5'd4, 5'd4, 5'd0};
    for (int t = 0; t < 4; t++) begin
      apply_reset();
      release_reset();
      set_inputs(1'b0, 1'b1, targets[t]);
      advance();
      run_free(2);
      set_inputs(1'b0, 1'b0, 32'h0);
      if (bus.ValidD !== 1'b1 || bus.PCOutD !== targets[t] || bus.ExcD !== excs[t] ||
          bus.InstrD !== ((excs[t] != 0) ? 32'h0 : mem_word(32'hFFF))) begin
        failures++; $display("FAIL addr_err t=%h got valid=%b pc=%h exc=%0d instr=%h exp exc=%0d",
                             targets[t], bus.ValidD, bus.PCOutD, bus.ExcD, bus.InstrD, excs[t]);
      end
      checks++;
      advance();
    end
    $display("test_addr_err done");
  endtask

  task automatic test_random();
    logic stall, flush;
    apply_reset();
    release_reset();
    for (int i = 0; i < 10000; i++) begin
      stall = ($urandom_range(0, 99) < 30);
      flush = ($urandom_range(0, 99) < 4);
      set_inputs(stall, flush, rand_target());
      if (bus.ValidD !== exp_valid) begin failures++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", i, bus.ValidD, exp_valid); end
      checks++;
      if (bus.PCOutD !== exp_pc) begin failures++; $display("FAIL rnd_pc cyc=%0d got=%h exp=%h", i, bus.PCOutD, exp_pc); end
      checks++;
      if (bus.InstrD !== exp_instr) begin failures++; $display("FAIL rnd_instr cyc=%0d got=%h exp=%h", i, bus.InstrD, exp_instr); end
      checks++;
      if (bus.ExcD !== exp_exc) begin failures++; $display("FAIL rnd_exc cyc=%0d got=%0d exp=%0d", i, bus.ExcD, exp_exc); end
      checks++;
      if (bus.PCEn !== exp_pcen) begin failures++; $display("FAIL rnd_pcen cyc=%0d got=%b exp=%b", i, bus.PCEn, exp_pcen); end
      checks++;
      if (!pc_bad(bus.PCF)) begin
        if (bus.ImAddr !== IM_AW'((bus.PCF - 32'h3000) / 4)) begin
          failures++; $display("FAIL rnd_imaddr cyc=%0d got=%h exp=%h", i, bus.ImAddr, IM_AW'((bus.PCF - 32'h3000) / 4));
        end
        checks++;
      end
      advance();
    end
    $display("test_random done");
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_free_run();
    test_stall();
    test_flush();
    test_addr_err();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
